// File: rtl/fp_pkg.sv
// Shared types and constants for the front-panel program loader.
package fp_pkg;

    localparam int unsigned ADR_W  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StSettle
    } fp_state_e;

    // One panel event is accepted per cycle; the encoding order is the priority order.
    typedef enum logic [2:0] {
        EvNone,
        EvWrite,
        EvNext,
        EvPrev,
        EvKey
    } fp_event_e;

    function automatic fp_event_e pick_event(input logic write_pulse, input logic next_pulse,
                                             input logic prev_pulse, input logic key_valid);
        fp_event_e ev;
        ev = EvNone;
        if (write_pulse) begin
            ev = EvWrite;
        end else if (next_pulse) begin
            ev = EvNext;
        end else if (prev_pulse) begin
            ev = EvPrev;
        end else if (key_valid) begin
            ev = EvKey;
        end
        return ev;
    endfunction

endpackage

// File: rtl/fp_tick_timer.sv
// Loadable down-counter stepped by the 1 kHz clken tick.
// done flags the tick on which the counter runs out, so the caller can leave on that edge.
module fp_tick_timer
    import fp_pkg::*;
#(
    parameter int unsigned CntW = CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clken,
    input  logic            load,
    input  logic            clear,
    input  logic [CntW-1:0] load_val,
    output logic            done
);

    logic [CntW-1:0] count;

    // Load wins over a coincident tick, so the entry tick never counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (clken && (count != '0)) begin
            count <= count - CntW'(1);
        end
    end

    // Last tick: the counter goes from 1 to 0 on this edge.
    always_comb begin
        done = clken && !load && (count <= CntW'(1));
    end

endmodule

// File: rtl/fp_loader.sv
// Front-panel loader: assembles keypad nibbles, steps the program address and
// drives a stretched write strobe into the core's programming port.
module fp_loader
    import fp_pkg::*;
#(
    parameter int unsigned WR_TICKS = 2,
    parameter int unsigned AUTO_INC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    input  logic              prog,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              next_pulse,
    input  logic              prev_pulse,
    input  logic              write_pulse,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADR_W-1:0]  fp_adr,
    output logic [DATA_W-1:0] fp_data,
    output logic              fp_write,
    output logic [1:0]        nibbles,
    output logic              busy
);

    fp_state_e state;
    fp_event_e ev;
    logic      write_q;
    logic      timer_load;
    logic      timer_done;

    // Decode the single accepted panel event for this cycle.
    always_comb begin
        ev         = pick_event(write_pulse, next_pulse, prev_pulse, key_valid);
        timer_load = prog && (state == StIdle) && (ev == EvWrite);
    end

    fp_tick_timer #(
        .CntW(CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clken   (clken),
        .load    (timer_load),
        .clear   (!prog),
        .load_val(CNT_W'(WR_TICKS)),
        .done    (timer_done)
    );

    // Loader FSM with the address, data and nibble-count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= StIdle;
            fp_adr  <= '0;
            fp_data <= '0;
            nibbles <= 2'd0;
            write_q <= 1'b0;
        end else if (!prog) begin
            // Leaving program mode abandons any operation; address and data are held.
            state   <= StIdle;
            write_q <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    unique case (ev)
                        EvWrite: begin
                            state   <= StWrite;
                            write_q <= 1'b1;
                        end
                        EvNext: begin
                            fp_adr <= fp_adr + ADR_W'(1);
                            state  <= StSettle;
                        end
                        EvPrev: begin
                            fp_adr <= fp_adr - ADR_W'(1);
                            state  <= StSettle;
                        end
                        EvKey: begin
                            fp_data <= {fp_data[3:0], key_code};
                            if (nibbles != 2'd2) begin
                                nibbles <= nibbles + 2'd1;
                            end
                        end
                        default: ;
                    endcase
                end
                StWrite: begin
                    if (timer_done) begin
                        write_q <= 1'b0;
                        if (AUTO_INC != 0) begin
                            fp_adr <= fp_adr + ADR_W'(1);
                            state  <= StSettle;
                        end else begin
                            nibbles <= 2'd0;
                            state   <= StIdle;
                        end
                    end
                end
                StSettle: begin
                    // Readback is only trusted once the core has seen a tick at the new address.
                    if (clken) begin
                        fp_data <= rd_data;
                        nibbles <= 2'd0;
                        state   <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Write strobe is gated by prog so it drops without waiting for a clock edge.
    always_comb begin
        fp_write = write_q && prog;
        busy     = (state != StIdle);
    end

endmodule

// File: tb/tb_fp_loader.sv
// Self-checking bench for fp_loader: auto-increment and non-incrementing instances.
module tb_fp_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       clken;
    logic       prog;
    logic       key_valid;
    logic [3:0] key_code;
    logic       next_pulse;
    logic       prev_pulse;
    logic       write_pulse;
    logic [7:0] rd_data;

    logic [3:0] a_adr, b_adr;
    logic [7:0] a_data, b_data;
    logic       a_wr, b_wr;
    logic [1:0] a_nib, b_nib;
    logic       a_busy, b_busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [15:0] vec;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    fp_loader #(.WR_TICKS(2), .AUTO_INC(1)) u_dut (
        .clk(clk), .reset(reset), .clken(clken), .prog(prog),
        .key_valid(key_valid), .key_code(key_code),
        .next_pulse(next_pulse), .prev_pulse(prev_pulse), .write_pulse(write_pulse),
        .rd_data(rd_data),
        .fp_adr(a_adr), .fp_data(a_data), .fp_write(a_wr), .nibbles(a_nib), .busy(a_busy)
    );

    fp_loader #(.WR_TICKS(2), .AUTO_INC(0)) u_dut_noinc (
        .clk(clk), .reset(reset), .clken(clken), .prog(prog),
        .key_valid(key_valid), .key_code(key_code),
        .next_pulse(next_pulse), .prev_pulse(prev_pulse), .write_pulse(write_pulse),
        .rd_data(rd_data),
        .fp_adr(b_adr), .fp_data(b_data), .fp_write(b_wr), .nibbles(b_nib), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Expected vector layout: {adr, data, nibbles, fp_write, busy}.
    task automatic push_exp(input string tag, input logic [3:0] adr, input logic [7:0] data,
                            input logic [1:0] nib, input logic wr, input logic bsy);
        exp_t e;
        e.tag = tag;
        e.vec = {adr, data, nib, wr, bsy};
        sb.push_back(e);
    endtask

    task automatic cmp_a();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            check(e.tag, {a_adr, a_data, a_nib, a_wr, a_busy}, e.vec);
        end
    endtask

    task automatic cmp_b();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            check(e.tag, {b_adr, b_data, b_nib, b_wr, b_busy}, e.vec);
        end
    endtask

    // Hold inputs for one clock, then return at the next falling edge.
    task automatic drive(input logic w, input logic n, input logic p, input logic k,
                         input logic [3:0] code, input logic ck);
        @(negedge clk);
        write_pulse = w;
        next_pulse  = n;
        prev_pulse  = p;
        key_valid   = k;
        key_code    = code;
        clken       = ck;
        @(negedge clk);
        write_pulse = 1'b0;
        next_pulse  = 1'b0;
        prev_pulse  = 1'b0;
        key_valid   = 1'b0;
        clken       = 1'b0;
    endtask

    task automatic key(input logic [3:0] code);
        drive(1'b0, 1'b0, 1'b0, 1'b1, code, 1'b0);
    endtask

    task automatic tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clken = 1'b0; prog = 1'b1; key_valid = 1'b0; key_code = 4'h0;
        next_pulse = 1'b0; prev_pulse = 1'b0; write_pulse = 1'b0; rd_data = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_exp("reset", 4'h0, 8'h00, 2'd0, 1'b0, 1'b0); cmp_a();

        // Nibble assembly and saturation.
        push_exp("key3", 4'h0, 8'h03, 2'd1, 1'b0, 1'b0); key(4'h3); cmp_a();
        push_exp("keyA", 4'h0, 8'h3A, 2'd2, 1'b0, 1'b0); key(4'hA); cmp_a();
        push_exp("key7", 4'h0, 8'hA7, 2'd2, 1'b0, 1'b0); key(4'h7); cmp_a();

        // Address wrap both ways with readback reload.
        rd_data = 8'h11;
        push_exp("prev_wrap", 4'hF, 8'hA7, 2'd2, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0); cmp_a();
        push_exp("settle_f", 4'hF, 8'h11, 2'd0, 1'b0, 1'b0); tick(); cmp_a();
        rd_data = 8'h5C;
        push_exp("next_wrap", 4'h0, 8'h11, 2'd0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0); cmp_a();
        push_exp("key_in_settle", 4'h0, 8'h11, 2'd0, 1'b0, 1'b1); key(4'h9); cmp_a();
        push_exp("settle_0", 4'h0, 8'h5C, 2'd0, 1'b0, 1'b0); tick(); cmp_a();

        // Walk to address 4.
        rd_data = 8'h00;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
            tick();
        end
        push_exp("at_4", 4'h4, 8'h00, 2'd0, 1'b0, 1'b0); cmp_a();
        key(4'h1);
        push_exp("data_1e", 4'h4, 8'h1E, 2'd2, 1'b0, 1'b0); key(4'hE); cmp_a();

        // Write with a coincident next_pulse and entry tick: both must be ignored.
        push_exp("wr_entry", 4'h4, 8'h1E, 2'd2, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1); cmp_a();
        push_exp("key_in_write", 4'h4, 8'h1E, 2'd2, 1'b1, 1'b1); key(4'h9); cmp_a();
        push_exp("wr_tick1", 4'h4, 8'h1E, 2'd2, 1'b1, 1'b1); tick(); cmp_a();
        repeat (3) @(negedge clk);
        push_exp("wr_hold", 4'h4, 8'h1E, 2'd2, 1'b1, 1'b1); cmp_a();
        @(negedge clk);
        clken = 1'b1;
        #1 check("wr_last_tick", 16'(a_wr), 16'd1);
        @(negedge clk);
        clken = 1'b0;
        rd_data = 8'h77;
        push_exp("wr_done", 4'h5, 8'h1E, 2'd2, 1'b0, 1'b1); cmp_a();
        push_exp("settle_5", 4'h5, 8'h77, 2'd0, 1'b0, 1'b0); tick(); cmp_a();

        // Non-incrementing instance.
        do_reset();
        key(4'h2);
        push_exp("b_keys", 4'h0, 8'h2B, 2'd2, 1'b0, 1'b0); key(4'hB); cmp_b();
        push_exp("b_wr", 4'h0, 8'h2B, 2'd2, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0); cmp_b();
        push_exp("b_tick1", 4'h0, 8'h2B, 2'd2, 1'b1, 1'b1); tick(); cmp_b();
        push_exp("b_done", 4'h0, 8'h2B, 2'd0, 1'b0, 1'b0); tick(); cmp_b();

        // prog dropped mid-write.
        do_reset();
        key(4'h4);
        push_exp("p_keys", 4'h0, 8'h42, 2'd2, 1'b0, 1'b0); key(4'h2); cmp_a();
        push_exp("p_wr", 4'h0, 8'h42, 2'd2, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0); cmp_a();
        @(negedge clk);
        prog = 1'b0;
        #1 check("p_wr_drop", 16'(a_wr), 16'd0);
        @(negedge clk);
        push_exp("p_idle", 4'h0, 8'h42, 2'd2, 1'b0, 1'b0); cmp_a();
        push_exp("p_ignored", 4'h0, 8'h42, 2'd2, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'h9, 1'b0); cmp_a();
        prog = 1'b1;
        push_exp("p_after", 4'h0, 8'h42, 2'd2, 1'b0, 1'b0); tick(); cmp_a();

        // Asynchronous reset during SETTLE.
        push_exp("r_next", 4'h1, 8'h42, 2'd2, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0); cmp_a();
        @(negedge clk);
        #2 reset = 1'b1;
        #1 push_exp("r_async", 4'h0, 8'h00, 2'd0, 1'b0, 1'b0); cmp_a();
        @(negedge clk);
        reset = 1'b0;
        push_exp("r_key", 4'h0, 8'h06, 2'd1, 1'b0, 1'b0); key(4'h6); cmp_a();

        check("sb_drained", 16'(sb.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
